// File: rtl/link_split_receiver_pkg.sv
// Shared constants and helpers for the link split receiver.
// Mode encodings, constant-time clog2 and a sign-safe magnitude helper.
package link_split_pkg;

  localparam logic MODE_SPLIT     = 1'b0;
  localparam logic MODE_BROADCAST = 1'b1;

  // Widest sample the magnitude helper handles; callers cast down to their own width.
  localparam int MAX_SAMPLE_W = 32;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Most-negative input maps to its true magnitude because the result is unsigned.
  function automatic logic [MAX_SAMPLE_W-1:0] abs_sample(input logic signed [MAX_SAMPLE_W-1:0] s);
    logic [MAX_SAMPLE_W-1:0] u;
    u = s;
    return u[MAX_SAMPLE_W-1] ? (~u + 32'd1) : u;
  endfunction

endpackage

// File: rtl/link_split_receiver_if.sv
// Front-end sample input and per-lane output bundle of the link split receiver.
// master = front end / consumers side, slave = receiver side.
interface link_split_receiver_if #(
  parameter int NUM_LANES = 2,
  parameter int SAMPLE_W  = 8
);

  logic [SAMPLE_W-1:0]           SampleIn;
  logic                          SampleValid;
  logic                          ModeSelect;
  logic [NUM_LANES*SAMPLE_W-1:0] LaneData;
  logic [NUM_LANES-1:0]          LaneValid;
  logic [NUM_LANES-1:0]          LaneReady;
  logic [NUM_LANES-1:0]          LaneActive;
  logic [NUM_LANES-1:0]          Overflow;
  logic                          OverflowClear;

  modport master (
    output SampleIn, SampleValid, ModeSelect, LaneReady, OverflowClear,
    input  LaneData, LaneValid, LaneActive, Overflow
  );

  modport slave (
    input  SampleIn, SampleValid, ModeSelect, LaneReady, OverflowClear,
    output LaneData, LaneValid, LaneActive, Overflow
  );

endinterface

// File: rtl/link_split_receiver_lane_fifo.sv
// Per-lane first-word-fall-through FIFO; a push shows at the head one cycle later.
// Full with a same-cycle pop still accepts the push; full without a pop drops it and pulses drop.
module lane_fifo
  import link_split_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 8
) (
  input  logic                core_clk,
  input  logic                rst_n,
  input  logic                push_vld,
  input  logic [SAMPLE_W-1:0] push_dat,
  output logic                pop_vld,
  input  logic                pop_rdy,
  output logic [SAMPLE_W-1:0] pop_dat,
  output logic                drop
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_q;
  logic [AW-1:0]       rd_q;
  logic [CW-1:0]       cnt_q;
  logic                full;
  logic                pop;
  logic                wr;

  assign pop_vld = (cnt_q != '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop     = pop_vld & pop_rdy;
  assign wr      = push_vld & (~full | pop);
  assign drop    = push_vld & full & ~pop;
  assign pop_dat = pop_vld ? mem[rd_q] : '0;

  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr)  wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge core_clk) begin
    if (wr) mem[wr_q] <= push_dat;
  end

endmodule

// File: rtl/link_split_receiver.sv
// Routes front-end samples to NUM_LANES FIFOs (round-robin or broadcast), one-cycle latency,
// per-lane valid/ready drain; a full lane drops its copy, flags sticky Overflow; energy per window.
module link_split_receiver
  import link_split_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int SAMPLE_W  = 8,
  parameter int DEPTH     = 8,
  parameter int WINDOW    = 64,
  parameter int THRESHOLD = 512
) (
  input logic                  Clock100Mhz,
  input logic                  ResetN,
  link_split_receiver_if.slave bus
);

  localparam int PTR_W = clog2(NUM_LANES);
  localparam int WIN_W = clog2(WINDOW);
  localparam int ACC_W = SAMPLE_W + WIN_W;

  logic                 mode_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [NUM_LANES-1:0] route;
  logic [NUM_LANES-1:0] drop;
  logic [NUM_LANES-1:0] lane_vld;
  logic [NUM_LANES-1:0] ovf_q;
  logic [NUM_LANES-1:0] active_q;
  logic [SAMPLE_W-1:0]  lane_dat [NUM_LANES];
  logic [ACC_W-1:0]     acc_q    [NUM_LANES];
  logic [ACC_W-1:0]     acc_sum  [NUM_LANES];
  logic [WIN_W-1:0]     win_q    [NUM_LANES];
  logic signed [MAX_SAMPLE_W-1:0] sample_ext;
  logic [SAMPLE_W-1:0]  sample_mag;

  assign sample_ext = MAX_SAMPLE_W'($signed(bus.SampleIn));
  assign sample_mag = SAMPLE_W'(abs_sample(sample_ext));

  always_comb begin
    route = '0;
    for (int i = 0; i < NUM_LANES; i++)
      route[i] = bus.SampleValid && (mode_q == MODE_BROADCAST || ptr_q == PTR_W'(i));
  end

  // The sample on the edge where the mode flips is still routed by the old mode.
  always_ff @(posedge Clock100Mhz) begin
    if (!ResetN) begin
      mode_q <= MODE_SPLIT;
      ptr_q  <= '0;
    end else begin
      mode_q <= bus.ModeSelect;
      if (bus.ModeSelect != mode_q)
        ptr_q <= '0;
      else if (bus.SampleValid && mode_q == MODE_SPLIT)
        ptr_q <= (ptr_q == PTR_W'(NUM_LANES - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++)
      acc_sum[i] = acc_q[i] + ACC_W'(sample_mag);
  end

  // Dropped samples still count towards energy: they were received on the link.
  always_ff @(posedge Clock100Mhz) begin
    if (!ResetN) begin
      active_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        acc_q[i] <= '0;
        win_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (route[i]) begin
          if (win_q[i] == WIN_W'(WINDOW - 1)) begin
            active_q[i] <= (32'(acc_sum[i]) >= 32'(THRESHOLD));
            acc_q[i]    <= '0;
            win_q[i]    <= '0;
          end else begin
            acc_q[i] <= acc_sum[i];
            win_q[i] <= win_q[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock100Mhz) begin
    if (!ResetN)
      ovf_q <= '0;
    else
      ovf_q <= (ovf_q & ~{NUM_LANES{bus.OverflowClear}}) | drop;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_fifo #(
      .SAMPLE_W (SAMPLE_W),
      .DEPTH    (DEPTH)
    ) u_fifo (
      .core_clk (Clock100Mhz),
      .rst_n    (ResetN),
      .push_vld (route[g]),
      .push_dat (bus.SampleIn),
      .pop_vld  (lane_vld[g]),
      .pop_rdy  (bus.LaneReady[g]),
      .pop_dat  (lane_dat[g]),
      .drop     (drop[g])
    );
    assign bus.LaneData[g*SAMPLE_W +: SAMPLE_W] = lane_dat[g];
  end

  assign bus.LaneValid  = lane_vld;
  assign bus.LaneActive = active_q;
  assign bus.Overflow   = ovf_q;

endmodule

// File: tb/tb_link_split_receiver.sv
// Scoreboard bench for link_split_receiver: a reference model fills per-lane expectation
// queues at each rising edge, a monitor compares and retires them on the falling edge.
module tb_link_split_receiver;

  localparam int NL = 2;
  localparam int SW = 8;
  localparam int DP = 8;
  localparam int WN = 64;
  localparam int TH = 512;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  link_split_receiver_if #(.NUM_LANES(NL), .SAMPLE_W(SW)) bus ();

  link_split_receiver #(
    .NUM_LANES (NL),
    .SAMPLE_W  (SW),
    .DEPTH     (DP),
    .WINDOW    (WN),
    .THRESHOLD (TH)
  ) dut (
    .Clock100Mhz (clk),
    .ResetN      (rstn),
    .bus         (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [SW-1:0] exp_q [NL][$];
  logic [NL-1:0] popped   = '0;
  logic [NL-1:0] m_active = '0;
  logic [NL-1:0] m_ovf    = '0;
  logic          m_mode   = 1'b0;
  int            m_ptr    = 0;
  int            m_sum [NL];
  int            m_cnt [NL];

  task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane%0d: got %0h, expected %0h at %0t", name, lane, act, exp, $time);
    end
  endtask

  // Reference model: what each lane must hold after this edge.
  always @(posedge clk) begin
    int s;
    int mag;
    int occ;
    bit routed;
    if (!rstn) begin
      for (int i = 0; i < NL; i++) begin
        exp_q[i].delete();
        m_sum[i] = 0;
        m_cnt[i] = 0;
      end
      m_active = '0;
      m_ovf    = '0;
      m_mode   = 1'b0;
      m_ptr    = 0;
    end else begin
      s   = $signed(bus.SampleIn);
      mag = (s < 0) ? -s : s;
      if (bus.OverflowClear) m_ovf = '0;
      for (int i = 0; i < NL; i++) begin
        occ    = exp_q[i].size() + int'(popped[i]);
        routed = bus.SampleValid && (m_mode || m_ptr == i);
        if (routed) begin
          if (occ < DP || popped[i]) exp_q[i].push_back(bus.SampleIn);
          else m_ovf[i] = 1'b1;
          m_sum[i] += mag;
          m_cnt[i] += 1;
          if (m_cnt[i] == WN) begin
            m_active[i] = (m_sum[i] >= TH);
            m_sum[i] = 0;
            m_cnt[i] = 0;
          end
        end
      end
      if (bus.ModeSelect != m_mode) begin
        m_mode = bus.ModeSelect;
        m_ptr  = 0;
      end else if (bus.SampleValid && !m_mode) begin
        m_ptr = (m_ptr + 1) % NL;
      end
    end
  end

  // Monitor: compare the head of each lane, retire it when the consumer takes it.
  always @(negedge clk) begin
    logic [NL-1:0] p;
    p = '0;
    for (int i = 0; i < NL; i++) begin
      check("lane_valid", i, 32'(bus.LaneValid[i]), 32'(exp_q[i].size() > 0));
      if (exp_q[i].size() > 0) begin
        check("lane_data", i, 32'(bus.LaneData[i*SW +: SW]), 32'(exp_q[i][0]));
        if (bus.LaneReady[i]) begin
          void'(exp_q[i].pop_front());
          p[i] = 1'b1;
        end
      end
      check("lane_active", i, 32'(bus.LaneActive[i]), 32'(m_active[i]));
      check("overflow", i, 32'(bus.Overflow[i]), 32'(m_ovf[i]));
    end
    popped = p;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] s);
    bus.SampleValid = 1'b1;
    bus.SampleIn    = s;
    tick();
    bus.SampleValid = 1'b0;
  endtask

  initial begin
    int cnt;
    rstn              = 1'b0;
    bus.SampleIn      = '0;
    bus.SampleValid   = 1'b0;
    bus.ModeSelect    = 1'b0;
    bus.LaneReady     = '0;
    bus.OverflowClear = 1'b0;
    repeat (3) tick();
    check("reset_data", 0, 32'(bus.LaneData), 32'd0);
    check("reset_valid", 0, 32'(bus.LaneValid), 32'd0);
    rstn = 1'b1;
    tick();

    // Split, both consumers ready.
    bus.LaneReady = 2'b11;
    for (int k = 1; k <= 4; k++) send(SW'(k));
    repeat (2) tick();

    // Broadcast and hold the head.
    bus.ModeSelect = 1'b1;
    tick();
    bus.LaneReady = 2'b00;
    send(8'h55);
    repeat (3) tick();
    bus.LaneReady = 2'b11;
    repeat (2) tick();

    // Lane 0 stalled through 20 split samples.
    bus.ModeSelect = 1'b0;
    repeat (2) tick();
    bus.LaneReady = 2'b10;
    for (int k = 0; k < 20; k++) send(SW'($urandom));
    check("ovf_after_fill", 0, 32'(bus.Overflow), 32'h1);
    bus.OverflowClear = 1'b1;
    tick();
    bus.OverflowClear = 1'b0;
    check("ovf_cleared", 0, 32'(bus.Overflow), 32'h0);

    // Full lane 0 with push and pop together.
    bus.LaneReady = 2'b11;
    send(8'hA5);
    bus.LaneReady = 2'b00;
    check("ovf_push_pop", 0, 32'(bus.Overflow), 32'h0);
    bus.LaneReady = 2'b01;
    cnt = 0;
    while (bus.LaneValid[0] && cnt < 20) begin
      tick();
      cnt++;
    end
    check("occupancy", 0, 32'(cnt), 32'd8);
    bus.LaneReady = 2'b11;
    repeat (3) tick();

    // Reset with buffered samples.
    bus.LaneReady  = 2'b00;
    bus.ModeSelect = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) send(SW'(k + 9));
    rstn = 1'b0;
    tick();
    check("reset_midop_valid", 0, 32'(bus.LaneValid), 32'h0);
    rstn = 1'b1;
    bus.LaneReady = 2'b11;
    tick();

    // Energy windows in broadcast.
    for (int k = 0; k < WN; k++) send(8'hF8);
    check("active_512", 0, 32'(bus.LaneActive), 32'h3);
    for (int k = 0; k < WN; k++) send(8'h07);
    check("active_448", 0, 32'(bus.LaneActive), 32'h0);
    for (int k = 0; k < 4; k++) send(8'h80);
    for (int k = 0; k < WN - 4; k++) send(8'h00);
    check("active_min_sample", 0, 32'(bus.LaneActive), 32'h3);

    // Mode toggle with ptr at lane 1.
    bus.ModeSelect = 1'b0;
    repeat (2) tick();
    bus.LaneReady = 2'b00;
    send(8'h11);
    bus.ModeSelect = 1'b1;
    tick();
    bus.ModeSelect = 1'b0;
    tick();
    send(8'h22);
    check("toggle_valid", 0, 32'(bus.LaneValid), 32'h1);
    check("toggle_head", 0, 32'(bus.LaneData[SW-1:0]), 32'h11);
    bus.LaneReady = 2'b11;
    repeat (4) tick();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bus.SampleValid   = ($urandom_range(0, 3) != 0);
      bus.SampleIn      = SW'($urandom);
      bus.LaneReady     = NL'($urandom);
      bus.OverflowClear = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) bus.ModeSelect = ~bus.ModeSelect;
      rstn = (k != 1500);
      tick();
    end
    bus.SampleValid   = 1'b0;
    bus.OverflowClear = 1'b0;
    bus.LaneReady     = 2'b11;
    rstn              = 1'b1;
    cnt = 0;
    while ((exp_q[0].size() + exp_q[1].size()) > 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("drain_done", 0, 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
